// File: rtl/cpu_pkg.sv
// Shared types and constants for the 8-bit breadboard CPU control path.
package cpu_pkg;

    localparam int unsigned CTRL_W = 16;
    localparam int unsigned STEP_W = 3;

    typedef logic [CTRL_W-1:0] ctrl_t;
    typedef logic [STEP_W-1:0] step_t;

    localparam step_t MAX_STEP = 3'd4;

    typedef enum logic [3:0] {
        OP_NOP = 4'b0000,
        OP_LDA = 4'b0001,
        OP_ADD = 4'b0010,
        OP_SUB = 4'b0011,
        OP_STA = 4'b0100,
        OP_LDI = 4'b0101,
        OP_JMP = 4'b0110,
        OP_JC  = 4'b0111,
        OP_JZ  = 4'b1000,
        OP_OUT = 4'b1110,
        OP_HLT = 4'b1111
    } opcode_t;

    localparam int unsigned CTRL_HLT = 15;
    localparam int unsigned CTRL_MI  = 14;
    localparam int unsigned CTRL_RI  = 13;
    localparam int unsigned CTRL_RO  = 12;
    localparam int unsigned CTRL_IO  = 11;
    localparam int unsigned CTRL_II  = 10;
    localparam int unsigned CTRL_AI  = 9;
    localparam int unsigned CTRL_AO  = 8;
    localparam int unsigned CTRL_EO  = 7;
    localparam int unsigned CTRL_SU  = 6;
    localparam int unsigned CTRL_BI  = 5;
    localparam int unsigned CTRL_OI  = 4;
    localparam int unsigned CTRL_CE  = 3;
    localparam int unsigned CTRL_CO  = 2;
    localparam int unsigned CTRL_J   = 1;
    localparam int unsigned CTRL_FI  = 0;

endpackage

// File: rtl/microcode_rom.sv
// Combinational microcode: (step, opcode, flags) -> control word and last-step marker.
module microcode_rom
    import cpu_pkg::*;
(
    input  step_t       step_i,
    input  logic [3:0]  opcode_i,
    input  logic        carry_i,
    input  logic        zero_i,
    output ctrl_t       ctrl_o,
    output logic        last_o
);

    opcode_t op;
    assign op = opcode_t'(opcode_i);

    always_comb begin
        ctrl_o = '0;
        last_o = 1'b0;
        case (step_i)
            3'd0: begin
                ctrl_o[CTRL_CO] = 1'b1;
                ctrl_o[CTRL_MI] = 1'b1;
            end
            3'd1: begin
                ctrl_o[CTRL_RO] = 1'b1;
                ctrl_o[CTRL_II] = 1'b1;
                ctrl_o[CTRL_CE] = 1'b1;
            end
            3'd2: begin
                last_o = 1'b1;
                case (op)
                    OP_LDA, OP_ADD, OP_SUB, OP_STA: begin
                        ctrl_o[CTRL_MI] = 1'b1;
                        ctrl_o[CTRL_IO] = 1'b1;
                        last_o          = 1'b0;
                    end
                    OP_LDI: begin
                        ctrl_o[CTRL_IO] = 1'b1;
                        ctrl_o[CTRL_AI] = 1'b1;
                    end
                    OP_JMP: begin
                        ctrl_o[CTRL_IO] = 1'b1;
                        ctrl_o[CTRL_J]  = 1'b1;
                    end
                    // Conditional jumps only look at flags here, in T2.
                    OP_JC: begin
                        ctrl_o[CTRL_IO] = carry_i;
                        ctrl_o[CTRL_J]  = carry_i;
                    end
                    OP_JZ: begin
                        ctrl_o[CTRL_IO] = zero_i;
                        ctrl_o[CTRL_J]  = zero_i;
                    end
                    OP_OUT: begin
                        ctrl_o[CTRL_AO] = 1'b1;
                        ctrl_o[CTRL_OI] = 1'b1;
                    end
                    OP_HLT: ctrl_o[CTRL_HLT] = 1'b1;
                    default: ;
                endcase
            end
            3'd3: begin
                last_o = 1'b1;
                case (op)
                    OP_LDA: begin
                        ctrl_o[CTRL_RO] = 1'b1;
                        ctrl_o[CTRL_AI] = 1'b1;
                    end
                    OP_ADD, OP_SUB: begin
                        ctrl_o[CTRL_RO] = 1'b1;
                        ctrl_o[CTRL_BI] = 1'b1;
                        last_o          = 1'b0;
                    end
                    OP_STA: begin
                        ctrl_o[CTRL_RI] = 1'b1;
                        ctrl_o[CTRL_AO] = 1'b1;
                    end
                    default: ;
                endcase
            end
            3'd4: begin
                last_o = 1'b1;
                if (op == OP_ADD || op == OP_SUB) begin
                    ctrl_o[CTRL_EO] = 1'b1;
                    ctrl_o[CTRL_AI] = 1'b1;
                    ctrl_o[CTRL_FI] = 1'b1;
                    ctrl_o[CTRL_SU] = (op == OP_SUB);
                end
            end
            default: last_o = 1'b1;
        endcase
    end

endmodule

// File: rtl/control_unit.sv
// Microstep sequencer: owns the step counter, the halted latch and the halt override on ctrl.
module control_unit
    import cpu_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        step_en,
    input  logic [3:0]  opcode,
    input  logic        carry_flag,
    input  logic        zero_flag,
    output ctrl_t       ctrl,
    output step_t       step,
    output logic        halted
);

    step_t step_q, step_d;
    logic  halted_q, halted_d;
    ctrl_t rom_ctrl;
    logic  rom_last;

    microcode_rom u_rom (
        .step_i   (step_q),
        .opcode_i (opcode),
        .carry_i  (carry_flag),
        .zero_i   (zero_flag),
        .ctrl_o   (rom_ctrl),
        .last_o   (rom_last)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            step_q   <= '0;
            halted_q <= 1'b0;
        end else begin
            step_q   <= step_d;
            halted_q <= halted_d;
        end
    end

    // HLT freezes the counter at T2 instead of wrapping.
    always_comb begin
        step_d   = step_q;
        halted_d = halted_q;
        if (step_en && !halted_q) begin
            if (rom_ctrl[CTRL_HLT]) begin
                halted_d = 1'b1;
            end else if (rom_last || step_q >= MAX_STEP) begin
                step_d = '0;
            end else begin
                step_d = step_t'(step_q + 3'd1);
            end
        end
    end

    always_comb begin
        ctrl = rom_ctrl;
        if (halted_q) begin
            ctrl                = '0;
            ctrl[CTRL_HLT]      = 1'b1;
        end
    end

    assign step   = step_q;
    assign halted = halted_q;

endmodule

// File: doc/control_unit.md
CONTROL_UNIT -- requirements
Module: control_unit

Interface
REQ-001 SHALL have port: clk  input  1  system clock; all state updates on rising edge.
REQ-002 SHALL have port: rst  input  1  reset; synchronous, active-high.
REQ-003 SHALL have port: step_en  input  1  microstep advance enable (run/single-step); state holds when low.
REQ-004 SHALL have port: opcode  input  4  upper nibble of instruction register.
REQ-005 SHALL have port: carry_flag  input  1  latched carry from flags register.
REQ-006 SHALL have port: zero_flag  input  1  latched zero from flags register.
REQ-007 SHALL have port: ctrl  output  16  control word; bit order [15]HLT [14]MI [13]RI [12]RO [11]IO [10]II [9]AI [8]AO [7]EO [6]SU [5]BI [4]OI [3]CE [2]CO [1]J [0]FI.
REQ-008 SHALL have port: step  output  3  current microstep T0..T4.
REQ-009 SHALL have port: halted  output  1  high once HLT has executed.
REQ-010 ctrl[6] (SU) SHALL drive the ALU subtract input directly; no other block generates it.

Function
REQ-011 ctrl SHALL be a combinational decode of (step, opcode, carry_flag, zero_flag, halted); no added latency.
REQ-012 Fetch SHALL be opcode-independent: T0 = CO|MI (0x4004); T1 = RO|II|CE (0x1408).
REQ-013 Execute words, T2/T3/T4: NOP 0000: 0x0000; LDA 0001: 0x4800/0x1200; ADD 0010: 0x4800/0x1020/0x0281; SUB 0011: 0x4800/0x1020/0x02C1; STA 0100: 0x4800/0x2100; LDI 0101: 0x0A00; JMP 0110: 0x0802; JC 0111: 0x0802 if carry_flag else 0x0000; JZ 1000: 0x0802 if zero_flag else 0x0000; OUT 1110: 0x0110; HLT 1111: 0x8000.
REQ-014 Undefined opcodes (1001-1101) SHALL execute as NOP.
REQ-015 Last step per opcode: LDA/STA T3; ADD/SUB T4; all others T2; T2 is the minimum, since opcode is only valid after T1.
REQ-016 On rising edge with step_en=1 and not halted: step SHALL go to 0 if at last step, else step+1.
REQ-017 step SHALL never exceed 4; any value 5-7 SHALL return to 0 on the next enabled edge.
REQ-018 With step_en=0, step and halted SHALL hold and ctrl SHALL remain stable for stable inputs.
REQ-019 JC/JZ flags SHALL be sampled combinationally during T2 only; a flag change at T0/T1 SHALL not affect ctrl.
REQ-020 At T2 with opcode=HLT, an enabled edge SHALL set halted=1 and hold step at 2.
REQ-021 While halted=1: ctrl SHALL equal 0x8000 regardless of opcode/flags; step SHALL freeze; step_en SHALL be ignored.
REQ-022 Only rst SHALL clear halted.

Reset
REQ-023 On rst=1 at a rising edge: step=0 and halted=0; ctrl then reads 0x4004.
REQ-024 rst SHALL override step_en, halted, and any in-progress instruction; mid-instruction reset restarts at T0 on the next cycle.

Structure
REQ-025 Shared package cpu_pkg SHALL hold: opcode enum, 16 control-bit index constants, ctrl word type, step type, and max-step constant (4).
REQ-026 Sub-module microcode_rom SHALL be combinational: (step, opcode, flags) -> ctrl word and last_step flag.
REQ-027 control_unit top SHALL own the step counter, the halted register, and the halted ctrl override.

Verification
REQ-028 rst, then step_en=1, opcode=0010 -> ctrl 0x4004, 0x1408, 0x4800, 0x1020, 0x0281, then step=0 and 0x4004.
REQ-029 opcode=0011 -> T4 ctrl 0x02C1 (SU set); opcode=0101 -> T2 0x0A00, next step=0.
REQ-030 opcode=0111, carry_flag=0 -> T2 0x0000, then step 0; carry_flag=1 -> T2 0x0802; same check for 1000 with zero_flag.
REQ-031 opcode=1111 -> T2 0x8000; after the edge halted=1, step=2, ctrl=0x8000 for 10 cycles despite step_en=1 and opcode changes; rst -> step=0, halted=0, ctrl 0x4004.
REQ-032 step_en=0 for 5 cycles at T3 of LDA -> step stays 3, ctrl 0x1200; rst asserted at T3 of ADD -> next cycle step=0, ctrl 0x4004.
REQ-033 opcode=1010 -> T2 0x0000 and return to T0 after T2.
